// File: rtl/icache_direct_mapped.sv
// Direct-mapped, word-addressed instruction cache with one 32-bit word per line.
// Hits return in the same cycle; misses fill through a req/ack handshake.
module icache_direct_mapped #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 32 - INDEX_BITS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_insn,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                state_r;
    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tag_r  [LINES];
    logic [31:0]           data_r [LINES];
    logic                  discard_r;
    logic                  mem_req_r;
    logic [31:0]           mem_addr_r;
    logic [31:0]           hit_count_r;
    logic [31:0]           miss_count_r;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [INDEX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]   fill_tag_s;
    logic                  hit_s;
    logic                  lookup_s;

    assign idx_s      = cpu_addr[INDEX_BITS-1:0];
    assign tag_s      = cpu_addr[31:INDEX_BITS];
    assign fill_idx_s = mem_addr_r[INDEX_BITS-1:0];
    assign fill_tag_s = mem_addr_r[31:INDEX_BITS];

    // Lookup and hit detection; only IDLE without flush or reset serves the CPU.
    always_comb begin
        hit_s     = 1'b0;
        lookup_s  = 1'b0;
        cpu_ready = 1'b0;
        cpu_insn  = 32'h0000_0000;
        if ((state_r == IDLE) && !flush && !reset) begin
            lookup_s = 1'b1;
        end else begin
            lookup_s = 1'b0;
        end
        hit_s = cpu_req && valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        if (lookup_s && hit_s) begin
            cpu_ready = 1'b1;
            cpu_insn  = data_r[idx_s];
        end else begin
            cpu_ready = 1'b0;
            cpu_insn  = 32'h0000_0000;
        end
    end

    // Controller FSM: valid bits, fill handshake, discard flag and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            discard_r    <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            hit_count_r  <= 32'h0000_0000;
            miss_count_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        valid_r <= '0;
                    end else if (hit_s) begin
                        hit_count_r <= hit_count_r + 32'd1;
                    end else if (cpu_req) begin
                        mem_addr_r   <= cpu_addr;
                        mem_req_r    <= 1'b1;
                        miss_count_r <= miss_count_r + 32'd1;
                        state_r      <= FILL;
                    end
                end
                FILL: begin
                    // A flush at any point of the fill, even on the ack edge, wins.
                    if (flush) begin
                        valid_r <= '0;
                    end else if (mem_ack && !discard_r) begin
                        valid_r[fill_idx_s] <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        discard_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        discard_r <= discard_r | flush;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    valid_r   <= '0;
                    discard_r <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage; overwritten unconditionally on a completed fill.
    always_ff @(posedge clock) begin
        if (!reset && (state_r == FILL) && mem_ack) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= mem_data;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: miss latency, conflicts, flush,
// redirect during fill, reset during fill and flush racing the fill ack.
module tb_icache_direct_mapped;
    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_insn;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;

    icache_direct_mapped #(.INDEX_BITS(4)) dut (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_insn(cpu_insn), .cpu_ready(cpu_ready), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Miss on addr in the current cycle, ack in the first FILL cycle.
    // Returns in the first cycle after the fill.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cyc();
        #1;
        chk("fill_req", {31'd0, mem_req}, 32'd1);
        chk("fill_addr", mem_addr, addr);
        mem_ack  = 1'b1;
        mem_data = data;
        cyc();
        mem_ack  = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'd0; flush = 1'b0;
        mem_ack = 1'b0; mem_data = 32'd0;
        cyc();
        cyc();
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_insn", cpu_insn, 32'd0);

        // Latency-3 miss on 0x5
        reset = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h5;
        #1;
        chk("t1_c0_ready", {31'd0, cpu_ready}, 32'd0);
        cyc(); #1;
        chk("t1_misses", miss_count, 32'd1);
        chk("t1_req1", {31'd0, mem_req}, 32'd1);
        chk("t1_addr1", mem_addr, 32'h5);
        chk("t1_insn_fill", cpu_insn, 32'd0);
        cyc(); #1;
        chk("t1_req2", {31'd0, mem_req}, 32'd1);
        cyc();
        mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
        #1;
        chk("t1_req3", {31'd0, mem_req}, 32'd1);
        chk("t1_no_comb_path", {31'd0, cpu_ready}, 32'd0);
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("t1_ready", {31'd0, cpu_ready}, 32'd1);
        chk("t1_insn", cpu_insn, 32'hDEADBEEF);
        chk("t1_req_low", {31'd0, mem_req}, 32'd0);
        chk("t1_hits_before", hit_count, 32'd0);
        cyc();
        cpu_req = 1'b0;
        #1;
        chk("t1_hits", hit_count, 32'd1);

        // Conflict between 0x05 and 0x15 after a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_miss(32'h05, 32'h11111111);
        chk("cf_first", cpu_insn, 32'h11111111);
        do_miss(32'h15, 32'h22222222);
        chk("cf_second", cpu_insn, 32'h22222222);
        cpu_addr = 32'h05;
        #1;
        chk("cf_evicted", {31'd0, cpu_ready}, 32'd0);
        do_miss(32'h05, 32'h11111111);
        chk("cf_misses", miss_count, 32'd3);
        chk("cf_third", cpu_insn, 32'h11111111);
        cyc(); #1;
        chk("cf_hits", hit_count, 32'd1);

        // Flush after a hit on 0x05
        flush = 1'b1;
        #1;
        chk("fl_ready", {31'd0, cpu_ready}, 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_hits", hit_count, 32'd1);
        chk("fl_misses", miss_count, 32'd3);
        chk("fl_now_miss", {31'd0, cpu_ready}, 32'd0);
        cyc(); #1;
        chk("fl_mem_req", {31'd0, mem_req}, 32'd1);
        chk("fl_misses2", miss_count, 32'd4);
        mem_ack = 1'b1; mem_data = 32'h33333333;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("fl_refill", cpu_insn, 32'h33333333);

        // Redirect during fill: 0x08 fill completes while PC moves to 0x09
        cpu_addr = 32'h08;
        cyc();
        cpu_addr = 32'h09;
        #1;
        chk("rd_addr1", mem_addr, 32'h8);
        cyc(); #1;
        chk("rd_addr2", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_data = 32'hAAAA0008;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("rd_9_miss", {31'd0, cpu_ready}, 32'd0);
        cyc(); #1;
        chk("rd_9_addr", mem_addr, 32'h9);
        mem_ack = 1'b1; mem_data = 32'h99990009;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("rd_9_hit", cpu_insn, 32'h99990009);
        cpu_addr = 32'h08;
        #1;
        chk("rd_8_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rd_8_insn", cpu_insn, 32'hAAAA0008);

        // Reset in the 2nd FILL cycle, stray ack afterwards
        cpu_addr = 32'h0C;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_data = 32'hBAD0BAD0;
        #1;
        chk("rm_req", {31'd0, mem_req}, 32'd0);
        chk("rm_hits", hit_count, 32'd0);
        chk("rm_misses", miss_count, 32'd0);
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("rm_ack_ignored", {31'd0, mem_req}, 32'd0);
        chk("rm_misses2", miss_count, 32'd0);
        cpu_req = 1'b1; cpu_addr = 32'h08;
        #1;
        chk("rm_line8_gone", {31'd0, cpu_ready}, 32'd0);
        cpu_addr = 32'h0C;
        #1;
        chk("rm_c_miss", {31'd0, cpu_ready}, 32'd0);
        do_miss(32'h0C, 32'hCCCC000C);
        chk("rm_c_hit", cpu_insn, 32'hCCCC000C);
        chk("rm_misses3", miss_count, 32'd1);

        // Flush coincident with mem_ack
        cpu_addr = 32'h03;
        cyc();
        mem_ack = 1'b1; flush = 1'b1; mem_data = 32'h30303030;
        cyc();
        mem_ack = 1'b0; flush = 1'b0;
        #1;
        chk("fa_req", {31'd0, mem_req}, 32'd0);
        chk("fa_not_valid", {31'd0, cpu_ready}, 32'd0);
        cyc(); #1;
        chk("fa_remiss", {31'd0, mem_req}, 32'd1);
        chk("fa_addr", mem_addr, 32'h3);
        chk("fa_misses", miss_count, 32'd3);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("fa_hit", cpu_insn, 32'h30303030);

        // Flush early in a fill discards the line
        cpu_addr = 32'h0A;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0; mem_ack = 1'b1; mem_data = 32'hA0A0A0A0;
        #1;
        chk("df_req", {31'd0, mem_req}, 32'd1);
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("df_discarded", {31'd0, cpu_ready}, 32'd0);
        chk("df_insn", cpu_insn, 32'd0);
        cyc(); #1;
        chk("df_refetch", {31'd0, mem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, word-addressed instruction cache between the processor's imem port (address_imem/q_imem) and a multi-cycle backing instruction memory.
- One 32-bit instruction per line.
- Hit: instruction is returned combinationally in the same cycle.
- Miss: the line is filled through a req/ack handshake. cpu_ready stays low so the fetch logic can hold the PC and F/D latch.
- Exports hit/miss counters for performance checks.

Parameters:
- INDEX_BITS, 4, log2 of the line count (default 16 lines); index = cpu_addr[INDEX_BITS-1:0].
- TAG_BITS, 32-INDEX_BITS, tag width; tag = cpu_addr[31:INDEX_BITS].

Ports:
- clock  input  1  master clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  fetch request valid (tied high by the processor).
- cpu_addr  input  32  word address of the instruction (PC).
- cpu_insn  output  32  instruction; 32'b0 (nop) whenever cpu_ready=0.
- cpu_ready  output  1  cpu_insn is valid this cycle.
- flush  input  1  invalidate all lines.
- mem_req  output  1  fill request to backing memory.
- mem_addr  output  32  fill word address; stable while mem_req=1.
- mem_ack  input  1  one-cycle pulse; mem_data is valid in that cycle.
- mem_data  input  32  fill data.
- hit_count  output  32  number of hits.
- miss_count  output  32  number of misses.

Behaviour:
- Storage: per line, valid[2^INDEX_BITS], tag[TAG_BITS], data[32]. Storage is registers, not a RAM macro.
- FSM states are IDLE and FILL.
- Reset (synchronous, any state, including mid-FILL):
  - All valid bits clear; state IDLE.
  - mem_req=0, mem_addr=0.
  - hit_count=0, miss_count=0.
  - cpu_ready=0, cpu_insn=0.
  - A mem_ack arriving after reset, while in IDLE, is ignored.
- hit = cpu_req & valid[idx] & (tag[idx]==cpu_addr[31:INDEX_BITS]).
- IDLE, no flush:
  - cpu_ready=hit and cpu_insn=hit ? data[idx] : 0, both combinational.
  - On hit: hit_count+1.
  - On cpu_req & !hit: latch mem_addr=cpu_addr, miss_count+1, go to FILL.
  - cpu_req=0: no action; cpu_ready=0.
- FILL:
  - mem_req=1, cpu_ready=0, cpu_insn=0.
  - mem_addr is held constant even if cpu_addr changes (branch redirect). The fill always completes for the latched address.
  - On the edge where mem_ack=1: write data[idx(mem_addr)]=mem_data and tag, set valid, go to IDLE.
  - mem_req is 0 from the following cycle. mem_ack is sampled only in FILL.
- Miss latency: with ack in cycle k after the miss cycle, the hit is delivered in cycle k+1 (given an unchanged cpu_addr).
  - Minimum miss-to-ready is 2 cycles (ack the first FILL cycle).
- Flush:
  - In IDLE, flush=1 forces cpu_ready=0 that cycle, clears all valid bits at the edge, and does no lookup and no counting.
  - In FILL, flush sets a discard flag. The handshake still completes on mem_ack, but the line is not marked valid. All valids are cleared at the flush edge; the flag is cleared on the return to IDLE.
- Simultaneous mem_ack and flush in FILL: the flush wins, the line is not validated, and the state goes to IDLE.
- Conflict: a fill overwrites the tag and data of the indexed line unconditionally (no victim handling).
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0. They are not cleared by flush.
- No combinational path from mem_data/mem_ack to cpu_insn/cpu_ready: a fill is visible only after the edge.

Test Plan:
- Reset, then cpu_addr=0x00000005 with memory latency 3 (ack in the 3rd FILL cycle, mem_data=0xDEADBEEF):
  - cycle0: cpu_ready=0, miss_count=1.
  - mem_req=1 with mem_addr=0x5 for 3 cycles.
  - The next cycle: cpu_ready=1, cpu_insn=0xDEADBEEF.
  - The following cycle: hit_count=1.
- Conflict: fill 0x05 (0x11111111), then 0x15 (0x22222222), then 0x05 again:
  - The third access misses, miss_count=3.
  - It returns 0x11111111 after its fill.
- Flush: after a hit on 0x05, pulse flush for one cycle:
  - cpu_ready=0 in the flush cycle.
  - The next access to 0x05 misses and mem_req rises.
  - Counters are unchanged by the flush.
- Redirect mid-fill: miss on 0x08; change cpu_addr to 0x09 during FILL; ack with 0xAAAA0008:
  - mem_addr stays 0x8.
  - Line 8 becomes valid.
  - Then 0x09 misses; after its fill, going back to 0x08 hits with 0xAAAA0008.
- Reset mid-fill: assert reset in the 2nd FILL cycle, and pulse mem_ack the cycle after:
  - mem_req=0 and the state is IDLE.
  - No line is valid; a re-access of the same address misses.
  - Counters are 0 before that access.
- Flush coincident with mem_ack in FILL:
  - The line is not valid and the state returns to IDLE.
  - The next access to the same address misses.
